// File: rtl/fp_add_seq.sv
// fp_add_seq: multi-cycle parametrised IEEE-754 adder/subtractor.
// Round-to-nearest-even, flush-to-zero, valid/ready on both sides.
module fp_add_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         flag_overflow,
  output logic         flag_underflow,
  output logic         flag_invalid
);
  localparam int SW = MAN_W + 4;
  localparam int XW = EXP_W + 2;
  localparam int RW = MAN_W + 2;
  localparam int LW = $clog2(SW + 1);
  localparam logic [EXP_W-1:0] EMAX = '1;
  localparam logic [EXP_W-1:0] SH_MAX = EXP_W'(SW - 1);
  localparam logic signed [XW-1:0] EMAX_X = {2'b00, EMAX};
  localparam logic [W-1:0] QNAN =
    {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE, ALIGN, ADD, NORM, ROUND, DONE
  } state_t;
  state_t state, nxt;

  logic [W-1:0] a_q, b_q;
  logic sub_q;
  logic sgn, zsgn, eff_sub, zero_q;
  logic is_nan, is_inf, inf_sgn;
  logic signed [XW-1:0] exp_q;
  logic [SW-1:0] big_q, sml_q;
  logic [SW:0] sum_q;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= nxt;

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (in_valid) nxt = ALIGN;
      ALIGN:   nxt = ADD;
      ADD:     nxt = NORM;
      NORM:    nxt = ROUND;
      ROUND:   nxt = DONE;
      DONE:    if (out_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  logic sa, sb, a_nan, b_nan, a_inf, b_inf, swap;
  logic [EXP_W-1:0] ea, eb, be, diff;
  logic [MAN_W-1:0] fa, fb;
  logic [MAN_W:0] sig_a, sig_b, bs, ss;
  logic [SW-1:0] ext, mask, shf;

  always_comb begin
    sa = a_q[W-1];
    ea = a_q[W-2:MAN_W];
    fa = a_q[MAN_W-1:0];
    sb = b_q[W-1] ^ sub_q;
    eb = b_q[W-2:MAN_W];
    fb = b_q[MAN_W-1:0];
    a_nan = (&ea) & (|fa);
    b_nan = (&eb) & (|fb);
    a_inf = (&ea) & ~(|fa);
    b_inf = (&eb) & ~(|fb);
    // exponent 0 flushes to a zero significand
    sig_a = (|ea) ? {1'b1, fa} : '0;
    sig_b = (|eb) ? {1'b1, fb} : '0;
    swap = {eb, fb} > {ea, fa};
    be = swap ? eb : ea;
    diff = swap ? (eb - ea) : (ea - eb);
    bs = swap ? sig_b : sig_a;
    ss = swap ? sig_a : sig_b;
    ext = {ss, 3'b000};
    mask = (SW'(1) << diff) - SW'(1);
    if (diff >= SH_MAX)
      shf = {{(SW-1){1'b0}}, |ss};
    else
      shf = (ext >> diff) |
            {{(SW-1){1'b0}}, |(ext & mask)};
  end

  logic [LW-1:0] lz;
  logic [SW-1:0] nm;
  logic signed [XW-1:0] ne;

  always_comb begin
    lz = '0;
    for (int i = 0; i < SW; i++)
      if (sum_q[i]) lz = LW'(SW - 1 - i);
    if (sum_q[SW]) begin
      nm = sum_q[SW:1] | {{(SW-1){1'b0}}, sum_q[0]};
      ne = exp_q + XW'(1);
    end else begin
      nm = sum_q[SW-1:0] << lz;
      ne = exp_q - XW'(lz);
    end
  end

  logic inc, ovf_c, unf_c, inv_c;
  logic [RW-1:0] rnd;
  logic signed [XW-1:0] re;
  logic [W-1:0] res_c;

  always_comb begin
    inc = big_q[2] & (big_q[1] | big_q[0] | big_q[3]);
    rnd = {1'b0, big_q[SW-1:3]} + RW'(inc);
    re = exp_q + XW'(rnd[MAN_W+1]);
    // a rounding carry leaves an all-zero fraction
    res_c = {sgn, re[EXP_W-1:0], rnd[MAN_W-1:0]};
    ovf_c = 1'b0;
    unf_c = 1'b0;
    inv_c = 1'b0;
    if (is_nan) begin
      res_c = QNAN;
      inv_c = 1'b1;
    end else if (is_inf) begin
      res_c = {inf_sgn, EMAX, {MAN_W{1'b0}}};
    end else if (zero_q) begin
      res_c = {zsgn, {(W-1){1'b0}}};
    end else if (exp_q <= 0) begin
      res_c = {sgn, {(W-1){1'b0}}};
      unf_c = 1'b1;
    end else if (re >= EMAX_X) begin
      res_c = {sgn, EMAX, {MAN_W{1'b0}}};
      ovf_c = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
      sub_q <= 1'b0;
      sgn <= 1'b0;
      zsgn <= 1'b0;
      eff_sub <= 1'b0;
      zero_q <= 1'b0;
      is_nan <= 1'b0;
      is_inf <= 1'b0;
      inf_sgn <= 1'b0;
      exp_q <= '0;
      big_q <= '0;
      sml_q <= '0;
      sum_q <= '0;
      result <= '0;
      flag_overflow <= 1'b0;
      flag_underflow <= 1'b0;
      flag_invalid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (in_valid) begin
          a_q <= a;
          b_q <= b;
          sub_q <= sub;
          flag_overflow <= 1'b0;
          flag_underflow <= 1'b0;
          flag_invalid <= 1'b0;
        end
        ALIGN: begin
          sgn <= swap ? sb : sa;
          zsgn <= sa & sb;
          eff_sub <= sa ^ sb;
          is_nan <= a_nan | b_nan | (a_inf & b_inf & (sa ^ sb));
          is_inf <= a_inf | b_inf;
          inf_sgn <= a_inf ? sa : sb;
          exp_q <= {2'b00, be};
          big_q <= {bs, 3'b000};
          sml_q <= shf;
        end
        ADD: sum_q <= eff_sub ?
          ({1'b0, big_q} - {1'b0, sml_q}) :
          ({1'b0, big_q} + {1'b0, sml_q});
        NORM: begin
          big_q <= nm;
          exp_q <= ne;
          zero_q <= ~(|sum_q);
        end
        ROUND: begin
          result <= res_c;
          flag_overflow <= ovf_c;
          flag_underflow <= unf_c;
          flag_invalid <= inv_c;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_add_seq.sv
// tb_fp_add_seq: directed vectors, corner sequences and random
// operands against an exact-arithmetic reference model.
module tb_fp_add_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0, in_ready, sub = 1'b0;
  logic out_valid, out_ready = 1'b1;
  logic [31:0] a = '0, b = '0, result;
  logic ovf, unf, inv;

  logic h_in_valid = 1'b0, h_in_ready, h_sub = 1'b0;
  logic h_out_valid, h_out_ready = 1'b1;
  logic [15:0] h_a = '0, h_b = '0, h_result;
  logic h_ovf, h_unf, h_inv;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fp_add_seq dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result),
    .flag_overflow(ovf), .flag_underflow(unf),
    .flag_invalid(inv)
  );

  fp_add_seq #(.EXP_W(5), .MAN_W(10)) dut_h (
    .clk(clk), .rst_n(rst_n),
    .in_valid(h_in_valid), .in_ready(h_in_ready),
    .a(h_a), .b(h_b), .sub(h_sub),
    .out_valid(h_out_valid), .out_ready(h_out_ready),
    .result(h_result),
    .flag_overflow(h_ovf), .flag_underflow(h_unf),
    .flag_invalid(h_inv)
  );

  task automatic check(input string nm,
                       input logic [63:0] got,
                       input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  // exact sum on a common integer grid, then one RNE rounding
  function automatic void model(input logic [31:0] x, y,
      input logic s, output logic [31:0] r,
      output logic ov, un, nv);
    logic sx, sy, sr;
    int ex, ey, p, e;
    bit [299:0] mx, my, mag, keep, rem, half, one;
    sx = x[31];
    sy = y[31] ^ s;
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    ov = 1'b0; un = 1'b0; nv = 1'b0;
    r = '0;
    if ((ex == 255 && x[22:0] != 0) || (ey == 255 && y[22:0] != 0) ||
        (ex == 255 && ey == 255 && sx != sy)) begin
      r = 32'h7FC00000;
      nv = 1'b1;
      return;
    end
    if (ex == 255) begin r = {sx, 8'hFF, 23'h0}; return; end
    if (ey == 255) begin r = {sy, 8'hFF, 23'h0}; return; end
    mx = '0; my = '0;
    if (ex != 0) begin mx = {1'b1, x[22:0]}; mx = mx << (ex - 1); end
    if (ey != 0) begin my = {1'b1, y[22:0]}; my = my << (ey - 1); end
    if (sx == sy) begin mag = mx + my; sr = sx; end
    else if (mx >= my) begin mag = mx - my; sr = sx; end
    else begin mag = my - mx; sr = sy; end
    if (mag == 0) begin r = {sx & sy, 31'h0}; return; end
    p = 0;
    for (int i = 0; i < 300; i++) if (mag[i]) p = i;
    e = p - 22;
    if (e <= 0) begin r = {sr, 31'h0}; un = 1'b1; return; end
    keep = mag >> (p - 23);
    if (p > 23) begin
      one = 1;
      rem = mag & ((one << (p - 23)) - 1);
      half = one << (p - 24);
      if (rem > half || (rem == half && keep[0])) keep = keep + 1;
    end
    if (keep[24]) begin keep = keep >> 1; e = e + 1; end
    if (e >= 255) begin r = {sr, 8'hFF, 23'h0}; ov = 1'b1; return; end
    r = {sr, 8'(e), keep[22:0]};
  endfunction

  task automatic issue(input logic [31:0] x, y, input logic s);
    int t;
    t = 0;
    a = x; b = y; sub = s; in_valid = 1'b1;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("accept", in_ready, 1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(output int lat);
    logic busy_bad;
    busy_bad = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 40) begin
      if (in_ready) busy_bad = 1'b1;
      @(negedge clk);
      lat++;
    end
    check("in_ready_busy", busy_bad, 1'b0);
    check("out_valid_seen", out_valid, 1'b1);
  endtask

  task automatic run(input string nm, input logic [31:0] x, y,
                     input logic s, input logic [31:0] er,
                     input logic eo, eu, ei, input logic hold);
    int lat;
    issue(x, y, s);
    wait_done(lat);
    check({nm, ".lat"}, lat, 5);
    check({nm, ".res"}, result, er);
    check({nm, ".flags"}, {ovf, unf, inv}, {eo, eu, ei});
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic h_run(input string nm, input logic [15:0] x, y,
                       input logic [15:0] er, input logic eo);
    int t;
    t = 0;
    @(negedge clk);
    h_a = x; h_b = y; h_sub = 1'b0; h_in_valid = 1'b1;
    @(posedge clk);
    #1;
    h_in_valid = 1'b0;
    while (!h_out_valid && t < 40) begin
      @(negedge clk);
      t++;
    end
    check({nm, ".valid"}, h_out_valid, 1'b1);
    check({nm, ".res"}, h_result, er);
    check({nm, ".ovf"}, h_ovf, eo);
  endtask

  typedef struct {
    string nm;
    logic [31:0] x, y;
    logic s;
    logic [31:0] r;
    logic ov, un, nv, hold;
  } vec_t;

  vec_t tbl[$];

  initial begin
    logic [31:0] x, y, er, r0;
    logic [2:0] f0;
    logic eo, eu, ei, bad;
    int lat;
    logic [31:0] sp[7];

    tbl.push_back('{"tie_even", 32'h3EEB851E, 32'h3F4A3D70, 1'b0, 32'h3FA00000, 0, 0, 0, 0});
    tbl.push_back('{"q_q", 32'h3E800000, 32'h3E800000, 1'b0, 32'h3F000000, 0, 0, 0, 1});
    tbl.push_back('{"q_h", 32'h3E800000, 32'h3F000000, 1'b0, 32'h3F400000, 0, 0, 0, 1});
    tbl.push_back('{"h_m_h", 32'h3F000000, 32'h3F000000, 1'b1, 32'h00000000, 0, 0, 0, 0});
    tbl.push_back('{"ovf", 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1, 0, 0, 0});
    tbl.push_back('{"inf_m_inf", 32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 0, 0, 1, 0});
    tbl.push_back('{"unf", 32'h00800000, 32'h00800001, 1'b1, 32'h80000000, 0, 1, 0, 0});
    tbl.push_back('{"subn_ftz", 32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 0, 0, 0, 0});
    tbl.push_back('{"nz_nz", 32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 0, 0, 0, 0});
    tbl.push_back('{"nan_in", 32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 0, 0, 1, 0});
    tbl.push_back('{"ninf", 32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 0, 0, 0, 0});
    tbl.push_back('{"sticky", 32'h3F800000, 32'h30800000, 1'b0, 32'h3F800000, 0, 0, 0, 0});
    tbl.push_back('{"one_m_ulp", 32'h3F800000, 32'h33800000, 1'b1, 32'h3F7FFFFF, 0, 0, 0, 0});
    tbl.push_back('{"tie_lo", 32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 0, 0, 0, 0});
    tbl.push_back('{"tie_up", 32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 0, 0, 0, 0});

    #1;
    check("rst.in_ready", in_ready, 1'b1);
    check("rst.out_valid", out_valid, 1'b0);
    check("rst.result", result, 32'h0);
    check("rst.flags", {ovf, unf, inv}, 3'b000);
    #11 rst_n = 1'b1;
    @(negedge clk);

    foreach (tbl[i])
      run(tbl[i].nm, tbl[i].x, tbl[i].y, tbl[i].s, tbl[i].r,
          tbl[i].ov, tbl[i].un, tbl[i].nv, tbl[i].hold);

    // backpressure in DONE
    @(negedge clk);
    out_ready = 1'b0;
    issue(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0);
    in_valid = 1'b0;
    wait_done(lat);
    check("bp.res", result, 32'h7F800000);
    check("bp.ovf", ovf, 1'b1);
    r0 = result;
    f0 = {ovf, unf, inv};
    bad = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (!out_valid || in_ready || result !== r0 ||
          {ovf, unf, inv} !== f0) bad = 1'b1;
    end
    check("bp.stable", bad, 1'b0);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("bp.out_valid_low", out_valid, 1'b0);
    check("bp.in_ready_high", in_ready, 1'b1);
    @(negedge clk);
    out_ready = 1'b1;

    // asynchronous reset while in NORM
    issue(32'h3F800000, 32'h3F800000, 1'b0);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("arst.out_valid", out_valid, 1'b0);
    check("arst.in_ready", in_ready, 1'b1);
    check("arst.result", result, 32'h0);
    check("arst.flags", {ovf, unf, inv}, 3'b000);
    #3 rst_n = 1'b1;
    bad = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) bad = 1'b1;
    end
    check("arst.no_valid", bad, 1'b0);
    run("post_rst", 32'h3F800000, 32'h3F800000, 1'b0,
        32'h40000000, 0, 0, 0, 0);

    h_run("half_1p1", 16'h3C00, 16'h3C00, 16'h4000, 1'b0);
    h_run("half_ovf", 16'h7BFF, 16'h7BFF, 16'h7C00, 1'b1);

    sp[0] = 32'h00000000; sp[1] = 32'h80000000;
    sp[2] = 32'h7F800000; sp[3] = 32'hFF800000;
    sp[4] = 32'h7FC00000; sp[5] = 32'h00000123;
    sp[6] = 32'h7F7FFFFF;
    for (int n = 0; n < 300; n++) begin
      int mode;
      x = $urandom;
      y = $urandom;
      mode = $urandom_range(0, 3);
      if (mode < 2) y[30:23] = x[30:23] + 8'($urandom_range(0, 4)) - 8'd2;
      if (mode == 3) begin
        case ($urandom_range(0, 8))
          7: y = x;
          8: y = x ^ 32'h80000000;
          default: y = sp[$urandom_range(0, 6)];
        endcase
      end
      model(x, y, n[0], er, eo, eu, ei);
      @(negedge clk);
      run("rnd", x, y, n[0], er, eo, eu, ei, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
